// File: rtl/spi_slv_pkg.sv
// Shared constants and FSM encodings for the SPI slave serial engine.
package spi_slv_pkg;

  localparam int CMD_RW_BIT = 7;
  localparam int FRAME_BITS = 8;
  localparam int ADDR7_W    = 7;

  typedef logic [2:0] spi_state_t;

  localparam spi_state_t ST_IDLE     = 3'd0;
  localparam spi_state_t ST_CMD      = 3'd1;
  localparam spi_state_t ST_WR_SHIFT = 3'd2;
  localparam spi_state_t ST_RD_FETCH = 3'd3;
  localparam spi_state_t ST_RD_SHIFT = 3'd4;

  function automatic logic [ADDR7_W-1:0] addr7_next(input logic [ADDR7_W-1:0] addr7);
    return addr7 + 7'd1;
  endfunction

endpackage

// File: rtl/spi_slv_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI pin with rise/fall detection
// taken from the last two synchronised samples.
module spi_slv_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic sys_clk,
  input  logic rst_b,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_r;
  logic                   prev_r;

  // synchroniser chain plus one history flop for edge detection
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      chain_r <= {SYNC_STAGES{RST_VAL}};
      prev_r  <= RST_VAL;
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], din};
      prev_r  <= chain_r[SYNC_STAGES-1];
    end
  end

  assign level = chain_r[SYNC_STAGES-1];
  assign rise  = chain_r[SYNC_STAGES-1] & ~prev_r;
  assign fall  = ~chain_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/spi_slave_serial_if.sv
// SPI mode-0 slave serial engine, oversampled in sys_clk, feeding the register file.
// Optional build macro SPI_SLV_DUMMY_EN inserts one dummy byte after a read command.
module spi_slave_serial_if
  import spi_slv_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RD_WAIT     = 4
) (
  input  logic       sys_clk,
  input  logic       rst_b,
  input  logic       sclk,
  input  logic       csb,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       spi_reg_wr_en,
  output logic       spi_reg_rd_en,
  output logic [7:0] spi_reg_addr,
  output logic [7:0] spi_reg_data,
  input  logic [7:0] reg_spi_data
);

`ifdef SPI_SLV_DUMMY_EN
  localparam logic DUMMY_EN = 1'b1;
`else
  localparam logic DUMMY_EN = 1'b0;
`endif

  localparam logic [2:0] LAST_BIT     = 3'(FRAME_BITS - 1);
  localparam logic [7:0] RD_WAIT_LAST = 8'(RD_WAIT - 1);

  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic csb_sync_s, csb_rise_s, csb_fall_s;
  logic mosi_sync_s;

  logic [SYNC_STAGES-1:0] mosi_chain_r;
  logic [SYNC_STAGES:0]   settle_r;
  logic                   armed_r;

  spi_state_t         state_r;
  logic [2:0]         bit_cnt_r;
  logic [6:0]         rx_r;
  logic [7:0]         tx_r;
  logic [7:0]         wait_cnt_r;
  logic [ADDR7_W-1:0] addr7_r;
  logic [7:0]         data_r;
  logic               addr_inc_r;
  logic               fetch_done_r;
  logic               dummy_r;
  logic               fall_skip_r;
  logic               wr_en_r;
  logic               rd_en_r;
  logic               miso_r;
  logic               miso_oe_r;

  spi_slv_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .sys_clk (sys_clk),
    .rst_b   (rst_b),
    .din     (sclk),
    .level   (sclk_lvl_s),
    .rise    (sclk_rise_s),
    .fall    (sclk_fall_s)
  );

  spi_slv_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csb_sync (
    .sys_clk (sys_clk),
    .rst_b   (rst_b),
    .din     (csb),
    .level   (csb_sync_s),
    .rise    (csb_rise_s),
    .fall    (csb_fall_s)
  );

  // mosi only needs alignment with the sclk samples, no edge detect
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      mosi_chain_r <= {SYNC_STAGES{1'b0}};
    end else begin
      mosi_chain_r <= {mosi_chain_r[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_sync_s = mosi_chain_r[SYNC_STAGES-1];

  // a frame may start only once csb has been seen high on real (post-reset) samples
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      settle_r <= '0;
      armed_r  <= 1'b0;
    end else begin
      settle_r <= {settle_r[SYNC_STAGES-1:0], 1'b1};
      armed_r  <= armed_r | (settle_r[SYNC_STAGES] & csb_sync_s);
    end
  end

  // frame FSM, shift registers, strobes and MISO bit
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      rx_r         <= 7'd0;
      tx_r         <= 8'd0;
      wait_cnt_r   <= 8'd0;
      addr7_r      <= 7'd0;
      data_r       <= 8'd0;
      addr_inc_r   <= 1'b0;
      fetch_done_r <= 1'b0;
      dummy_r      <= 1'b0;
      fall_skip_r  <= 1'b0;
      wr_en_r      <= 1'b0;
      rd_en_r      <= 1'b0;
      miso_r       <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      rd_en_r <= 1'b0;
      if (addr_inc_r) begin
        addr7_r    <= addr7_next(addr7_r);
        addr_inc_r <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          bit_cnt_r <= 3'd0;
          miso_r    <= 1'b0;
          if (csb_fall_s && armed_r) begin
            state_r <= ST_CMD;
          end
        end

        ST_CMD: begin
          if (csb_sync_s) begin
            state_r <= ST_IDLE;
          end else if (sclk_rise_s) begin
            rx_r      <= {rx_r[5:0], mosi_sync_s};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == LAST_BIT) begin
              addr7_r <= {rx_r[5:0], mosi_sync_s};
              if (rx_r[CMD_RW_BIT-1]) begin
                state_r      <= ST_RD_FETCH;
                rd_en_r      <= 1'b1;
                wait_cnt_r   <= 8'd0;
                fetch_done_r <= 1'b0;
                dummy_r      <= DUMMY_EN;
                fall_skip_r  <= 1'b1;
              end else begin
                state_r <= ST_WR_SHIFT;
              end
            end
          end
        end

        ST_WR_SHIFT: begin
          // a completed byte wins over a simultaneous csb release
          if (sclk_rise_s && (bit_cnt_r == LAST_BIT)) begin
            data_r     <= {rx_r, mosi_sync_s};
            wr_en_r    <= 1'b1;
            addr_inc_r <= 1'b1;
            bit_cnt_r  <= 3'd0;
            state_r    <= csb_sync_s ? ST_IDLE : ST_WR_SHIFT;
          end else if (csb_sync_s) begin
            state_r <= ST_IDLE;
          end else if (sclk_rise_s) begin
            rx_r      <= {rx_r[5:0], mosi_sync_s};
            bit_cnt_r <= bit_cnt_r + 3'd1;
          end
        end

        ST_RD_FETCH: begin
          if (csb_sync_s) begin
            state_r <= ST_IDLE;
            miso_r  <= 1'b0;
          end else begin
            if (sclk_fall_s) begin
              fall_skip_r <= 1'b0;
            end
            if (!fetch_done_r) begin
              if (wait_cnt_r == RD_WAIT_LAST) begin
                tx_r         <= reg_spi_data;
                fetch_done_r <= 1'b1;
              end else begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
              end
            end
            if (dummy_r && sclk_rise_s) begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == LAST_BIT) begin
                dummy_r     <= 1'b0;
                fall_skip_r <= 1'b1;
              end
            end
            if (fetch_done_r && !dummy_r) begin
              state_r   <= ST_RD_SHIFT;
              miso_r    <= tx_r[7];
              bit_cnt_r <= 3'd0;
            end
          end
        end

        ST_RD_SHIFT: begin
          if (csb_sync_s) begin
            state_r <= ST_IDLE;
            miso_r  <= 1'b0;
          end else if (sclk_fall_s) begin
            // the fall trailing the byte boundary belongs to the previous byte
            if (fall_skip_r) begin
              fall_skip_r <= 1'b0;
            end else begin
              tx_r   <= {tx_r[6:0], 1'b0};
              miso_r <= tx_r[6];
            end
          end else if (sclk_rise_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == LAST_BIT) begin
              addr7_r      <= addr7_next(addr7_r);
              rd_en_r      <= 1'b1;
              wait_cnt_r   <= 8'd0;
              fetch_done_r <= 1'b0;
              dummy_r      <= 1'b0;
              fall_skip_r  <= 1'b1;
              state_r      <= ST_RD_FETCH;
            end
          end
        end

        default: begin
          state_r <= ST_IDLE;
          miso_r  <= 1'b0;
        end
      endcase
    end
  end

  // pad enable follows the read states, dropped as soon as csb is seen high
  always_ff @(posedge sys_clk or negedge rst_b) begin
    if (!rst_b) begin
      miso_oe_r <= 1'b0;
    end else begin
      miso_oe_r <= ((state_r == ST_RD_FETCH) || (state_r == ST_RD_SHIFT)) && !csb_sync_s;
    end
  end

  assign miso          = miso_r;
  assign miso_oe       = miso_oe_r;
  assign spi_reg_wr_en = wr_en_r;
  assign spi_reg_rd_en = rd_en_r;
  assign spi_reg_addr  = {1'b0, addr7_r};
  assign spi_reg_data  = data_r;

endmodule

// File: doc/spi_slave_serial_if.md
Name: spi_slave_serial_if

Overview:
- SPI mode-0 slave serial engine, oversampled in the sys_clk domain; directly upstream of the SPI slave register file.
- Deserialises host frames of command byte + data bytes.
- Write frames: issues write strobes with address and data to the register file.
- Read frames: issues read strobes and serialises the returned reg_spi_data onto MISO.

Parameters:
- SYNC_STAGES, 2, flop stages on sclk/mosi/csb before edge detection (min 2).
- RD_WAIT, 4, sys_clk cycles from spi_reg_rd_en assertion to capture of reg_spi_data. Covers the register file's 2-flop sync plus 1 registered read.

Ports:
- sys_clk  in  1  system clock
- rst_b  in  1  asynchronous active-low reset
- sclk  in  1  SPI clock from host, async, idle low
- csb  in  1  SPI chip select, active low, async
- mosi  in  1  SPI data in, async
- miso  out  1  SPI data out
- miso_oe  out  1  MISO pad output enable
- spi_reg_wr_en  out  1  write strobe, 1-cycle pulse
- spi_reg_rd_en  out  1  read strobe, 1-cycle pulse
- spi_reg_addr  out  8  register address, {1'b0, addr7}
- spi_reg_data  out  8  write data
- reg_spi_data  in  8  read data returned by register file

Behaviour:
- Reset: miso=0, miso_oe=0, spi_reg_wr_en=0, spi_reg_rd_en=0, spi_reg_addr=0, spi_reg_data=0, FSM=IDLE, all sync flops = idle (sclk 0, csb 1).
- Input sync and edge detection:
  - sclk, csb and mosi each pass through SYNC_STAGES flops.
  - rise/fall of sclk detected from the last two synced samples.
  - Edges are only acted on while synced csb=0.
- Serial format:
  - MSB first.
  - MOSI sampled on sclk rise; MISO updated on sclk fall.
  - Command byte: bit7 = R/W (1 = read), bits6:0 = addr7.
- FSM states: IDLE, CMD, WR_SHIFT, RD_FETCH, RD_SHIFT.
  - IDLE -> CMD: synced csb falls; bit counter cleared.
  - CMD: shift 8 bits. On the 8th rise, latch addr7 into spi_reg_addr, then:
    - R/W=0 -> WR_SHIFT.
    - R/W=1 -> RD_FETCH.
  - WR_SHIFT, on the 8th rise:
    - spi_reg_data <= shifted byte, spi_reg_wr_en=1 for one cycle.
    - Next cycle, addr7 increments.
    - Stay in WR_SHIFT (burst).
  - RD_FETCH:
    - Pulse spi_reg_rd_en for one cycle; count RD_WAIT cycles.
    - Then load reg_spi_data into tx shift register; miso = tx[7]; -> RD_SHIFT.
  - RD_SHIFT:
    - Each sclk fall shifts tx left; miso = new tx[7].
    - On the 8th rise of the byte: addr7 increments and FSM -> RD_FETCH (prefetch next byte for burst).
- spi_reg_addr/spi_reg_data remain stable from strobe until next update. Minimum stable time is guaranteed ≥ 3 cycles by the SCLK rate limit; the register file double-samples them.
- miso_oe=1 only in RD_FETCH/RD_SHIFT with csb low; miso=0 otherwise.
- Address wrap: addr7 7'h7F + 1 -> 7'h00; spi_reg_addr[7] always 0.
- Timing constraint (no feature): SCLK high and low each ≥ 6 sys_clk (f_sclk ≤ f_sys/12). First read bit must be valid before data rise 1.
- csb rises mid-byte (synced): FSM -> IDLE in the same cycle, partial byte discarded, no strobe issued, miso_oe=0 next cycle.
- csb rises in the same cycle as an 8th-bit rise: the write completes first, then -> IDLE.
- csb rises during RD_FETCH: an already-issued rd_en is harmless; capture is abandoned.
- rst_b asserted mid-frame: all state returns to reset values immediately. Host frame resumes only after csb toggles high then low.
- SCLK edges while csb high: ignored.

Optional Feature:
- Macro: SPI_SLV_DUMMY_EN.
- Defined:
  - Reads insert one 8-clock dummy byte after the command; MISO is driven 0 during it.
  - RD_FETCH overlaps the dummy byte; the data byte follows.
  - Constraint relaxed to SCLK high/low ≥ 4 sys_clk.
  - Burst reads prefetch without further dummy bytes.
- Undefined: no dummy byte; read data follows the command immediately under the 6-cycle constraint.

Decomposition:
- Package spi_slv_pkg:
  - FSM state enum.
  - CMD_RW_BIT=7.
  - FRAME_BITS=8.
  - ADDR7_W=7.
- Sub-module spi_slv_sync_edge: SYNC_STAGES synchroniser plus rise/fall detect, instanced for sclk and csb; mosi uses sync only.

Test Plan:
- Write: csb low, send 8'h05, 8'hA5 -> one spi_reg_wr_en pulse with spi_reg_addr=8'h05, spi_reg_data=8'hA5; miso_oe stays 0.
- Read: send 8'h83 with reg_spi_data model returning 8'h33 after 3 cycles -> one rd_en at addr 8'h03; MISO shifts 0,0,1,1,0,0,1,1.
- Burst write wrap: cmd 8'h7F then data 8'h11, 8'h22 -> writes at 8'h7F then 8'h00.
- Burst read: cmd 8'h80, 3 data bytes -> rd_en at 8'h00, 8'h01, 8'h02, 8'h03; MISO returns regs 0..2.
- Abort: csb high after 5 bits of data byte -> no wr_en, FSM IDLE; next full frame behaves normally.
- Reset mid-read: assert rst_b during RD_SHIFT -> all outputs 0, miso_oe=0. With SPI_SLV_DUMMY_EN, repeat the read test with 8 dummy clocks -> same data at half the sys_clk margin.
